// File: rtl/clock_pkg.sv
// Shared constants and types for the time display path: 7-segment patterns,
// digit count, decimal-point placement and the conversion FSM state type.
package clock_pkg;

  localparam int NUM_DIGITS = 6;

  // Digits that carry a separator dot: minutes ones (2) and hours ones (4).
  localparam logic [NUM_DIGITS-1:0] DP_DIGIT_MASK = 6'b010100;

  // Segment patterns for 0-9, bit0 = a ... bit6 = g, active-high.
  localparam logic [6:0] SEG7_PATTERNS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Out-of-range codes cannot be produced by the converter; they map to dark.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = 7'h00;
    if (digit < 4'd10) pattern = SEG7_PATTERNS[digit];
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD for one 6-bit field by repeated subtraction of 10.
// done is high in the cycle the remainder drops below 10; tens/ones are valid
// then. A start always restarts the conversion, so the parent may chain the
// next field in the same cycle it consumes done.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] value,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] work;
  logic       active;

  // Load on start, otherwise peel off one ten per cycle until below 10.
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      tens   <= '0;
      active <= 1'b0;
    end else if (start) begin
      work   <= value;
      tens   <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (work >= 6'd10) begin
        work <= work - 6'd10;
        tens <= tens + 4'd1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done = active && (work < 6'd10);
  assign ones = work[3:0];

endmodule

// File: rtl/time_display_scan.sv
// Snapshots hours/minutes/seconds on a load pulse, converts each field to two
// BCD digits with one time-shared sequential divider, and scans the result
// onto a 6-digit multiplexed 7-segment display with ghost-suppression blanking.
//
// state  | meaning
// IDLE   | display stable, waiting for a load pulse
// CONV   | divider working on field 'field' (0 sec, 1 min, 2 hr)
// COMMIT | all six digits copied to the display registers in one cycle
module time_display_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iLoad,
  input  logic [5:0] iHours,
  input  logic [5:0] iMinutes,
  input  logic [5:0] iSeconds,
  input  logic       iColon,
  input  logic       iLzb,
  output logic [6:0] oSeg,
  output logic       oDp,
  output logic [5:0] oAn,
  output logic       oBusy
);

  import clock_pkg::*;

  localparam int                SLOT_W     = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END  = SLOT_W'(BLANK_CYC);
  localparam logic [2:0]        LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic              POL        = (ACTIVE_LOW != 0);

  conv_state_t state;
  logic [1:0]  field;
  logic        busy;

  logic [5:0]  cap_hours;
  logic [5:0]  cap_minutes;

  logic        pend_valid;
  logic [5:0]  pend_hours;
  logic [5:0]  pend_minutes;
  logic [5:0]  pend_seconds;

  logic [NUM_DIGITS-1:0][3:0] res_digits;
  logic [NUM_DIGITS-1:0][3:0] disp_digits;

  logic        cvt_start;
  logic [5:0]  cvt_value;
  logic        cvt_done;
  logic [3:0]  cvt_tens;
  logic [3:0]  cvt_ones;

  logic [SLOT_W-1:0] slot_cnt;
  logic [2:0]        digit_idx;

  logic [3:0]  cur_digit;
  logic [5:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  bin2bcd_seq u_bin2bcd (
    .clk   (iClk),
    .rst   (iRst),
    .start (cvt_start),
    .value (cvt_value),
    .done  (cvt_done),
    .tens  (cvt_tens),
    .ones  (cvt_ones)
  );

  // Feed the shared divider: first field on capture, next field as each
  // finishes, and a fresh seconds value when COMMIT chains into a new load.
  always_comb begin
    cvt_start = 1'b0;
    cvt_value = '0;
    case (state)
      IDLE: begin
        if (iLoad) begin
          cvt_start = 1'b1;
          cvt_value = iSeconds;
        end
      end
      CONV: begin
        if (cvt_done && field == 2'd0) begin
          cvt_start = 1'b1;
          cvt_value = cap_minutes;
        end else if (cvt_done && field == 2'd1) begin
          cvt_start = 1'b1;
          cvt_value = cap_hours;
        end
      end
      COMMIT: begin
        if (iLoad) begin
          cvt_start = 1'b1;
          cvt_value = iSeconds;
        end else if (pend_valid) begin
          cvt_start = 1'b1;
          cvt_value = pend_seconds;
        end
      end
      default: ;
    endcase
  end

  // Conversion FSM with capture/pending registers and the display registers.
  // A load arriving during COMMIT bypasses the pending register; it is the
  // newest value and wins over anything already pending.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= IDLE;
      field        <= 2'd0;
      busy         <= 1'b0;
      cap_hours    <= '0;
      cap_minutes  <= '0;
      pend_valid   <= 1'b0;
      pend_hours   <= '0;
      pend_minutes <= '0;
      pend_seconds <= '0;
      res_digits   <= '0;
      disp_digits  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iLoad) begin
            cap_hours   <= iHours;
            cap_minutes <= iMinutes;
            field       <= 2'd0;
            busy        <= 1'b1;
            state       <= CONV;
          end
        end
        CONV: begin
          if (iLoad) begin
            pend_valid   <= 1'b1;
            pend_hours   <= iHours;
            pend_minutes <= iMinutes;
            pend_seconds <= iSeconds;
          end
          if (cvt_done) begin
            res_digits[{field, 1'b0}] <= cvt_ones;
            res_digits[{field, 1'b1}] <= cvt_tens;
            if (field == 2'd2) begin
              state <= COMMIT;
            end else begin
              field <= field + 2'd1;
            end
          end
        end
        COMMIT: begin
          disp_digits <= res_digits;
          field       <= 2'd0;
          pend_valid  <= 1'b0;
          if (iLoad) begin
            cap_hours   <= iHours;
            cap_minutes <= iMinutes;
            state       <= CONV;
          end else if (pend_valid) begin
            cap_hours   <= pend_hours;
            cap_minutes <= pend_minutes;
            state       <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign oBusy = busy;

  // Free-running scan: slot counter within a digit, digit index across slots.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Active-high drive for the current slot: dark during blanking, otherwise
  // one anode plus its decoded digit; hours-tens may be suppressed when zero.
  always_comb begin
    cur_digit = disp_digits[digit_idx];
    an_next   = '0;
    seg_next  = '0;
    dp_next   = 1'b0;
    if (slot_cnt >= BLANK_END) begin
      an_next = 6'b000001 << digit_idx;
      if (!(digit_idx == LAST_DIGIT && iLzb && cur_digit == 4'd0)) begin
        seg_next = seg7_decode(cur_digit);
      end
      dp_next = iColon & DP_DIGIT_MASK[digit_idx];
    end
  end

  // Output register; polarity is applied here so every pin is glitch-free.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oAn  <= {6{POL}};
      oSeg <= {7{POL}};
      oDp  <= POL;
    end else begin
      oAn  <= an_next ^ {6{POL}};
      oSeg <= seg_next ^ {7{POL}};
      oDp  <= dp_next ^ POL;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench: two instances (active-high and active-low) share all
// inputs and are compared every cycle against a behavioural model that works
// in decimal time values and conversion-cost arithmetic.
module tb_time_display_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [5:0] hrs, mins, secs;
  logic       colon, lzb;

  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;
  logic [5:0] an_h, an_l;
  logic       busy_h, busy_l;

  time_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0)) dut_hi (
    .iClk(clk), .iRst(rst), .iLoad(load), .iHours(hrs), .iMinutes(mins),
    .iSeconds(secs), .iColon(colon), .iLzb(lzb),
    .oSeg(seg_h), .oDp(dp_h), .oAn(an_h), .oBusy(busy_h)
  );

  time_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) dut_lo (
    .iClk(clk), .iRst(rst), .iLoad(load), .iHours(hrs), .iMinutes(mins),
    .iSeconds(secs), .iColon(colon), .iLzb(lzb),
    .oSeg(seg_l), .oDp(dp_l), .oAn(an_l), .oBusy(busy_l)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference segment table, a..g in bit0..bit6.
  logic [6:0] seg_ref [10];
  initial begin
    seg_ref[0] = 7'b0111111; seg_ref[1] = 7'b0000110; seg_ref[2] = 7'b1011011;
    seg_ref[3] = 7'b1001111; seg_ref[4] = 7'b1100110; seg_ref[5] = 7'b1101101;
    seg_ref[6] = 7'b1111101; seg_ref[7] = 7'b0000111; seg_ref[8] = 7'b1111111;
    seg_ref[9] = 7'b1101111;
  end

  // Model state: scan position, shown time, in-flight and pending conversions.
  int m_slot, m_digit;
  int disp_h, disp_m, disp_s;
  int rem;
  int cv_h, cv_m, cv_s;
  bit pend;
  int pv_h, pv_m, pv_s;
  logic [5:0] e_an, e_an_n;
  logic [6:0] e_seg, e_seg_n;
  logic       e_dp, e_dp_n, e_busy;

  // Busy cycles for one conversion: per field floor(v/10)+1, plus COMMIT.
  function automatic int conv_cost(input int h, input int m, input int s);
    return (h / 10 + 1) + (m / 10 + 1) + (s / 10 + 1) + 1;
  endfunction

  function automatic int digit_of(input int idx);
    case (idx)
      0: return disp_s % 10;
      1: return disp_s / 10;
      2: return disp_m % 10;
      3: return disp_m / 10;
      4: return disp_h % 10;
      default: return disp_h / 10;
    endcase
  endfunction

  task automatic model_edge();
    int d;
    if (rst) begin
      e_an = '0; e_seg = '0; e_dp = 1'b0;
      m_slot = 0; m_digit = 0;
      disp_h = 0; disp_m = 0; disp_s = 0;
      rem = 0; pend = 1'b0; e_busy = 1'b0;
    end else begin
      if (m_slot < BC) begin
        e_an = '0; e_seg = '0; e_dp = 1'b0;
      end else begin
        e_an = 6'(1 << m_digit);
        d = digit_of(m_digit);
        e_seg = (m_digit == 5 && lzb && d == 0) ? 7'd0 : seg_ref[d];
        e_dp = colon && (m_digit == 2 || m_digit == 4);
      end
      m_slot++;
      if (m_slot == SD) begin
        m_slot = 0;
        m_digit = (m_digit + 1) % 6;
      end
      if (rem > 0) begin
        if (load) begin
          pend = 1'b1; pv_h = int'(hrs); pv_m = int'(mins); pv_s = int'(secs);
        end
        rem--;
        if (rem == 0) begin
          disp_h = cv_h; disp_m = cv_m; disp_s = cv_s;
          if (pend) begin
            cv_h = pv_h; cv_m = pv_m; cv_s = pv_s;
            pend = 1'b0;
            rem = conv_cost(cv_h, cv_m, cv_s);
          end
        end
      end else if (load) begin
        cv_h = int'(hrs); cv_m = int'(mins); cv_s = int'(secs);
        rem = conv_cost(cv_h, cv_m, cv_s);
      end
      e_busy = (rem > 0);
    end
    e_an_n  = ~e_an;
    e_seg_n = ~e_seg;
    e_dp_n  = ~e_dp;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("an",     32'(an_h),   32'(e_an));
    check_val("seg",    32'(seg_h),  32'(e_seg));
    check_val("dp",     32'(dp_h),   32'(e_dp));
    check_val("busy",   32'(busy_h), 32'(e_busy));
    check_val("an_n",   32'(an_l),   32'(e_an_n));
    check_val("seg_n",  32'(seg_l),  32'(e_seg_n));
    check_val("dp_n",   32'(dp_l),   32'(e_dp_n));
    check_val("busy_n", 32'(busy_l), 32'(e_busy));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load(input int h, input int m, input int s);
    hrs = 6'(h); mins = 6'(m); secs = 6'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  int busy_cnt;
  int gap;

  initial begin
    rst = 1'b1; load = 1'b0; hrs = '0; mins = '0; secs = '0;
    colon = 1'b0; lzb = 1'b0;
    tick();
    tick();
    check_val("rst_an_lo",  32'(an_l),  32'h3F);
    check_val("rst_seg_lo", 32'(seg_l), 32'h7F);
    check_val("rst_an_hi",  32'(an_h),  32'h00);
    rst = 1'b0;

    // Idle scan of 00:00:00 over more than a full refresh.
    run(60);

    // 23:59:59: busy for exactly 16 cycles.
    pulse_load(23, 59, 59);
    busy_cnt = (busy_h === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy_h === 1'b1) busy_cnt++;
    end
    check_val("busy_len", 32'(busy_cnt), 32'd16);
    run(50);

    // Back-to-back loads: second arrives four cycles after the first.
    colon = 1'b1;
    pulse_load(12, 34, 56);
    run(3);
    pulse_load(1, 2, 3);
    run(100);

    // Leading-zero blanking on and off.
    lzb = 1'b1;
    pulse_load(5, 0, 0);
    run(70);
    lzb = 1'b0;
    run(50);

    // Reset five cycles into a conversion; nothing must commit afterwards.
    pulse_load(45, 45, 45);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(80);

    // Randomised loads, gaps short enough to exercise the pending path.
    for (int n = 0; n < 250; n++) begin
      colon = 1'($urandom_range(0, 1));
      lzb   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      pulse_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)));
      gap = int'($urandom_range(0, 30));
      run(gap);
    end
    run(120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
# time_display_scan

Downstream consumer of the seconds/minutes/hours counter chain in the complex clock design.
- Snapshots the three 6-bit counter values on a load pulse, typically the seconds counter strobe.
- Converts each value to two BCD digits with a sequential divide-by-10.
- Drives a 6-digit multiplexed 7-segment display with per-slot blanking for ghost suppression, separator dots and optional leading-zero blanking.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles per digit slot; legal range ≥ 4.
- BLANK_CYC, default 500: cycles at the start of each slot with all anodes off; legal range 1 to SCAN_DIV-2.
- ACTIVE_LOW, default 1: 1 means oSeg, oDp and oAn are active-low; 0 means active-high.

Ports (one clock; reset is synchronous and active-high):
- iClk  in  1  system clock
- iRst  in  1  synchronous active-high reset
- iLoad  in  1  single-cycle pulse; capture iHours/iMinutes/iSeconds this cycle
- iHours  in  6  hours value, binary
- iMinutes  in  6  minutes value, binary
- iSeconds  in  6  seconds value, binary
- iColon  in  1  1 lights the separator dots
- iLzb  in  1  1 blanks the hours-tens digit when it is zero
- oSeg  out  7  segments a..g, bit0 = a
- oDp  out  1  decimal point
- oAn  out  6  digit anodes, one-hot when active; bit0 = seconds ones, bit5 = hours tens
- oBusy  out  1  conversion in progress

## Operation
- Conversion FSM states: IDLE, CONV, COMMIT.
- IDLE: on iLoad, capture all three inputs into work registers, set field index to 0 (seconds), go to CONV.
- CONV, per field:
  - If work ≥ 10: subtract 10 and increment the tens count.
  - Otherwise: ones = work. Advance the field (seconds, then minutes, then hours); after hours, go to COMMIT.
- COMMIT: copy all six BCD digits into the display registers in one cycle, then return to IDLE.
- Values above 59 are not clamped. Example: 63 displays "63".
- iLoad while in CONV or COMMIT:
  - The inputs are captured into a pending register and a pending flag is set. The latest iLoad wins.
  - On leaving COMMIT with the flag set, go directly to CONV using the pending values and clear the flag.
- iLoad in the same cycle as COMMIT counts as pending.
- oBusy = 1 in CONV and COMMIT.
- Scan: slot counter 0..SCAN_DIV-1; digit index 0..5.
  - The digit index advances when the slot counter = SCAN_DIV-1, wrapping from 5 to 0.
  - Slot counter < BLANK_CYC: all anodes inactive, all segments inactive.
  - Otherwise: the anode for the current digit is active and oSeg carries the decoded digit.
- Segment decode for 0-9 uses standard patterns. BCD values above 9 cannot occur.
- oDp is active only on digit 2 and digit 4, only when iColon = 1 and not blanking.
- When iLzb = 1 and the hours tens digit = 0, digit 5 shows all segments inactive; its anode is still driven.
- ACTIVE_LOW inverts oSeg, oDp and oAn at the output register.

## Timing
- All outputs are registered. oSeg/oDp/oAn reflect the (slot counter, digit index, display registers) state of the previous cycle.
- Reset (iRst = 1 at a clock edge): the following cycle shows:
  - oAn, oSeg and oDp all inactive;
  - oBusy = 0;
  - slot counter = 0, digit index = 0;
  - display registers = 0, FSM = IDLE, pending flag cleared.
- A reset mid-conversion discards the work registers and the pending values.
- Conversion latency from the iLoad cycle to the display update:
  - 1 capture cycle;
  - plus Σ(floor(v/10)+1) CONV cycles over the three fields;
  - plus 1 COMMIT cycle.
  - Example: 23:59:59 gives 1 + 6 + 6 + 3 + 1 = 17 cycles.
- Maximum latency is 1 + 3×7 + 1 = 23 cycles, for 63:63:63.
- New digits become visible on the output the cycle after COMMIT, in whatever slot is current. All six digits swap in the same cycle; no partial update is ever visible.
- The scan runs continuously and independently of the FSM. A full refresh period is 6×SCAN_DIV cycles.

## Structure
- Package clock_pkg holds:
  - the seg7 pattern constant array for 0-9;
  - NUM_DIGITS = 6;
  - the conversion-state enum (IDLE, CONV, COMMIT);
  - DP_DIGIT_MASK = 6'b010100.
- Sub-module bin2bcd_seq performs the one-field divide-by-10 via repeated subtraction with start/done. It is instantiated once and time-shared across the three fields by the parent FSM.
- The parent module contains the capture/pending registers, the FSM, the display registers, the scan counters and the output register.

## Test plan
- Reset, then run with SCAN_DIV = 8, BLANK_CYC = 2, ACTIVE_LOW = 0:
  - oAn cycles 000001 → 000010 → … → 100000 → 000001, 8 cycles per slot;
  - oAn = 0 for the first 2 cycles of each slot;
  - oSeg = 0111111 ("0") while lit.
- iLoad with 23:59:59: oBusy high for 16 cycles; then digits 5..0 show 2, 3, 5, 9, 5, 9 (digit 5 oSeg = 1011011); total latency 17 cycles.
- iLoad 12:34:56, then a second iLoad with 01:02:03 four cycles later: display goes to 12:34:56, then the conversion restarts immediately and the final display is 01:02:03 with no idle cycle between.
- iLzb = 1, iLoad 05:00:00: digit 5 anode active, oSeg = 0. With iLzb = 0 the same digit shows "0".
- iColon = 1: oDp is active only while oAn = 000100 or 010000, and inactive during blanking. With ACTIVE_LOW = 1 all outputs are inverted, and the reset value is oAn = 111111, oSeg = 1111111.
- Assert iRst 5 cycles into a conversion of 45:45:45: oBusy = 0 the next cycle, the display stays at 00:00:00, and no later COMMIT occurs.
